spi_frame_ctrl: RTL
===================

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: SPI word width; SHALL be >= 8, header fields use bits [7:0].
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles allowed between accepted words inside a frame.
REQ-003 clk  in  1  system clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  WIDTH  last completed SPI word (from spi.data).
REQ-006 rx_valid  in  1  SPI word pending (from spi.data_valid).
REQ-007 rx_clear  out  1  registered one-cycle pulse acknowledging a word (to spi.clear).
REQ-008 wr_en  out  1  register-file write strobe.
REQ-009 wr_addr  out  4  register-file write address.
REQ-010 wr_data  out  WIDTH  register-file write data.
REQ-011 frame_done  out  1  one-cycle pulse: frame committed.
REQ-012 frame_err  out  1  one-cycle pulse: frame rejected.
REQ-013 busy  out  1  high whenever state != IDLE.

Function
REQ-014 Frame format SHALL be: header (bits[7:4] = 4'hA sync, bits[3:0] = LEN), LEN payload words, one checksum word.
REQ-015 Checksum SHALL be the bitwise XOR of header and all payload words at full WIDTH; frame valid iff received checksum equals it.
REQ-016 A word SHALL be accepted on an edge iff rx_valid=1, rx_clear=0 and state is IDLE, PAYLOAD or CHECK; acceptance sets rx_clear=1 for exactly the next cycle.
REQ-017 No word SHALL be accepted in COMMIT; a pending rx_valid SHALL remain unacknowledged until the return to IDLE.
REQ-018 States SHALL be IDLE, PAYLOAD, CHECK, COMMIT.
REQ-019 IDLE: accepted word with sync=4'hA and LEN 1..15 -> load LEN, init XOR to header, clear index -> PAYLOAD.
REQ-020 IDLE: accepted word with bad sync or LEN=0 -> frame_err pulse, stay IDLE.
REQ-021 PAYLOAD: each accepted word stored in 16xWIDTH internal buffer at index, XOR updated, index++; after LEN-th word -> CHECK.
REQ-022 CHECK: accepted word matching XOR -> COMMIT; mismatch -> frame_err pulse -> IDLE, no wr_en.
REQ-023 COMMIT: wr_en=1 for exactly LEN consecutive cycles, wr_addr = 0..LEN-1, wr_data = buffer[wr_addr]; frame_done pulses the cycle after the last write; then IDLE.
REQ-024 Timeout counter SHALL clear on every accepted word and on entry to PAYLOAD, count in PAYLOAD/CHECK; reaching TIMEOUT_CYCLES -> frame_err pulse, IDLE, buffer contents not written.
REQ-025 Timeout and acceptance on the same edge: acceptance SHALL win.
REQ-026 frame_err and frame_done SHALL never assert in the same cycle; wr_en SHALL be low outside COMMIT.
REQ-027 Register-file contents from a rejected frame SHALL be unchanged.

Reset
REQ-028 On reset (any time, including mid-frame or mid-COMMIT): state=IDLE, rx_clear=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0, busy=0, counters/XOR cleared; partial frame discarded.
REQ-029 After reset release, the first accepted word SHALL be treated as a header.

Verification
REQ-030 Words A2,11,22,91 -> four rx_clear pulses; wr (0,11),(1,22) on consecutive cycles; frame_done next cycle; busy low after.
REQ-031 Words A1,55,00 -> frame_err once after third word; wr_en never high.
REQ-032 Word 30 then A0 -> each consumed, frame_err pulse each, busy stays 0; following A1,7E,DF commits (0,7E).
REQ-033 A3,01 then silence -> frame_err exactly TIMEOUT_CYCLES cycles after last accept; next good frame commits normally.
REQ-034 rx_valid held high during COMMIT of 15-word frame -> no rx_clear until IDLE, then word accepted as header.
REQ-035 Reset asserted after A4,01,02 -> outputs at reset values immediately; then A1,05,A4 commits (0,05) only.

Source files
------------

// File: rtl/spi_frame_ctrl_if.sv
// Bundles the SPI receive handshake and the register-file write port of the
// frame controller. The slave modport is the controller's view.
interface spi_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_clear;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             frame_done;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  rx_data, rx_valid,
        output rx_clear, wr_en, wr_addr, wr_data, frame_done, frame_err, busy
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_clear, wr_en, wr_addr, wr_data, frame_done, frame_err, busy
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Receives header / payload / XOR-checksum frames word by word from an SPI slave,
// buffers the payload and only writes it to the register file once the checksum matches.
module spi_frame_ctrl #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    spi_frame_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_buf [16];
    logic [3:0]       r_len;
    logic [3:0]       r_idx;
    logic [3:0]       r_cidx;
    logic [WIDTH-1:0] r_xor;
    logic [TW-1:0]    r_tmo;

    logic             r_rx_clear;
    logic             r_wr_en;
    logic [3:0]       r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_frame_done;
    logic             r_frame_err;

    logic             w_accept;
    logic             w_hdr_ok;
    logic             w_timeout;
    logic             w_write;
    logic             w_err_next;
    logic             w_done_next;

    // rx_clear is still high on the edge after an accept, which blocks a double take
    assign w_accept  = bus.rx_valid && !r_rx_clear && (r_state != COMMIT);
    assign w_hdr_ok  = (bus.rx_data[7:4] == 4'hA) && (bus.rx_data[3:0] != 4'd0);
    assign w_timeout = ((r_state == PAYLOAD) || (r_state == CHECK)) && !w_accept
                       && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = 1'b0;
        w_done_next  = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_hdr_ok) w_state_next = PAYLOAD;
                    else          w_err_next   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (w_accept) begin
                    if (r_idx == r_len - 4'd1) w_state_next = CHECK;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            CHECK: begin
                if (w_accept) begin
                    if (bus.rx_data == r_xor) begin
                        w_state_next = COMMIT;
                    end else begin
                        w_state_next = IDLE;
                        w_err_next   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            COMMIT: begin
                // Writes leave through registers, so COMMIT lasts one cycle past the last issue
                if (r_cidx == r_len) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_write = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept && (r_state == PAYLOAD)) r_buf[r_idx] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_clear   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 4'd0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_len        <= 4'd0;
            r_idx        <= 4'd0;
            r_cidx       <= 4'd0;
            r_xor        <= '0;
            r_tmo        <= '0;
        end else begin
            r_rx_clear   <= w_accept;
            r_frame_err  <= w_err_next;
            r_frame_done <= w_done_next;
            r_wr_en      <= w_write;
            r_wr_addr    <= w_write ? r_cidx : 4'd0;
            r_wr_data    <= w_write ? r_buf[r_cidx] : '0;
            if (w_write) r_cidx <= r_cidx + 4'd1;

            if (w_accept)                                      r_tmo <= '0;
            else if ((r_state == PAYLOAD) || (r_state == CHECK)) r_tmo <= r_tmo + TW'(1);
            else                                               r_tmo <= '0;

            if (w_accept && (r_state == IDLE) && w_hdr_ok) begin
                r_len  <= bus.rx_data[3:0];
                r_xor  <= bus.rx_data;
                r_idx  <= 4'd0;
                r_cidx <= 4'd0;
            end else if (w_accept && (r_state == PAYLOAD)) begin
                r_xor <= r_xor ^ bus.rx_data;
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign bus.rx_clear   = r_rx_clear;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != IDLE);
endmodule
